id_ex_stage: RTL and testbench

ID/EX pipeline stage directly upstream of the 8-bit ALU. It captures decoded operation, operands and destination from decode, and resolves data hazards by forwarding from the EX/MEM and MEM/WB stages. It applies stall and flush from the hazard/branch logic and drives aluOp/srcA/srcB into the ALU, inserting a NOP bubble (aluOp 5'b00000) on flush. It also keeps a saturating stall-cycle counter for debug.

---
 rtl/cpu_pkg.sv | 36 +++
 rtl/id_ex_stage_if.sv | 63 ++++++
 rtl/id_ex_stage_fwd_mux.sv | 38 +++
 rtl/id_ex_stage.sv | 102 ++++++++++
 tb/tb_id_ex_stage.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the ID/EX stage and its neighbours.
//   - Datapath widths (DATA_W, OP_W, REG_AW).
//   - ALU operation encodings (ALU_NOP is the bubble op).
//   - id_ex_t: the complete contents of the ID/EX pipeline register.
//   - bubble(): the register value that represents "no instruction".
package cpu_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 5;
  localparam int REG_AW = 4;

  localparam logic [OP_W-1:0] ALU_NOP    = 5'b00000;
  localparam logic [OP_W-1:0] ALU_PASS_B = 5'b00001;
  localparam logic [OP_W-1:0] ALU_INC    = 5'b00100;

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   alu_op;
    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic [DATA_W-1:0] rs1_val;
    logic [DATA_W-1:0] rs2_val;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
  } id_ex_t;

  // A bubble has every field zero. ALU_NOP is all-zero, and zero source
  // addresses keep the forwarding muxes idle while the stage is empty.
  function automatic id_ex_t bubble();
    id_ex_t b;
    b        = '0;
    b.alu_op = ALU_NOP;
    return b;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: all non-clock signals of the ID/EX stage bundled together.
//   Decode side : dec_valid, dec_alu_op, dec_rs1/rs2_addr, dec_rs1/rs2_val,
//                 dec_rd_addr, dec_reg_write
//   Control     : stall, flush
//   Forwarding  : exm_reg_write/rd_addr/result, mwb_reg_write/rd_addr/result
//   ALU side    : ex_valid, ex_alu_op, ex_src_a, ex_src_b, ex_rd_addr,
//                 ex_reg_write
//   Debug       : stall_cnt (CNT_W bits)
// master: the surrounding pipeline (drives decode/control/forwarding).
// slave : the ID/EX stage itself.
interface id_ex_stage_if #(
  parameter int CNT_W = 16
);
  import cpu_pkg::*;

  logic              dec_valid;
  logic [OP_W-1:0]   dec_alu_op;
  logic [REG_AW-1:0] dec_rs1_addr;
  logic [REG_AW-1:0] dec_rs2_addr;
  logic [DATA_W-1:0] dec_rs1_val;
  logic [DATA_W-1:0] dec_rs2_val;
  logic [REG_AW-1:0] dec_rd_addr;
  logic              dec_reg_write;

  logic              stall;
  logic              flush;

  logic              exm_reg_write;
  logic [REG_AW-1:0] exm_rd_addr;
  logic [DATA_W-1:0] exm_result;
  logic              mwb_reg_write;
  logic [REG_AW-1:0] mwb_rd_addr;
  logic [DATA_W-1:0] mwb_result;

  logic              ex_valid;
  logic [OP_W-1:0]   ex_alu_op;
  logic [DATA_W-1:0] ex_src_a;
  logic [DATA_W-1:0] ex_src_b;
  logic [REG_AW-1:0] ex_rd_addr;
  logic              ex_reg_write;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output dec_valid, dec_alu_op, dec_rs1_addr, dec_rs2_addr,
           dec_rs1_val, dec_rs2_val, dec_rd_addr, dec_reg_write,
           stall, flush,
           exm_reg_write, exm_rd_addr, exm_result,
           mwb_reg_write, mwb_rd_addr, mwb_result,
    input  ex_valid, ex_alu_op, ex_src_a, ex_src_b, ex_rd_addr,
           ex_reg_write, stall_cnt
  );

  modport slave (
    input  dec_valid, dec_alu_op, dec_rs1_addr, dec_rs2_addr,
           dec_rs1_val, dec_rs2_val, dec_rd_addr, dec_reg_write,
           stall, flush,
           exm_reg_write, exm_rd_addr, exm_result,
           mwb_reg_write, mwb_rd_addr, mwb_result,
    output ex_valid, ex_alu_op, ex_src_a, ex_src_b, ex_rd_addr,
           ex_reg_write, stall_cnt
  );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// fwd_mux: selects the freshest value of one source operand.
//   rs_addr/rs_val       : registered operand address and register-file value
//   exm_reg_write/rd/res : EX/MEM forwarding bus (highest priority)
//   mwb_reg_write/rd/res : MEM/WB forwarding bus
//   fwd_val              : selected operand value
// Register 0 is hard-wired to zero in the register file, so a write aimed at
// it must never be forwarded.
module fwd_mux
  import cpu_pkg::*;
(
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [DATA_W-1:0] rs_val,
  input  logic              exm_reg_write,
  input  logic [REG_AW-1:0] exm_rd_addr,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              mwb_reg_write,
  input  logic [REG_AW-1:0] mwb_rd_addr,
  input  logic [DATA_W-1:0] mwb_result,
  output logic [DATA_W-1:0] fwd_val
);

  logic exm_hit;
  logic mwb_hit;

  assign exm_hit = exm_reg_write && (exm_rd_addr == rs_addr) && (rs_addr != '0);
  assign mwb_hit = mwb_reg_write && (mwb_rd_addr == rs_addr) && (rs_addr != '0);

  // EX/MEM holds the younger producer, so it wins when both match.
  always_comb begin
    fwd_val = rs_val;
    if (exm_hit) begin
      fwd_val = exm_result;
    end else if (mwb_hit) begin
      fwd_val = mwb_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register feeding the 8-bit ALU.
//   clk   : rising-edge clock
//   rst_n : asynchronous, active-low reset
//   bus   : id_ex_stage_if.slave (decode inputs, stall/flush, forwarding
//           buses, ALU-side outputs and the debug stall counter)
// Priority per edge is flush > stall > load. Operands are forwarded
// combinationally on the way out; while stalled the operand registers are
// refreshed with the forwarded values so a producer leaving MEM/WB during
// the stall is not lost. stall_cnt counts stalled edges and saturates.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  id_ex_stage_if.slave  bus
);

  id_ex_t            stage_q;
  id_ex_t            stage_next;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;

  fwd_mux u_fwd_a (
    .rs_addr       (stage_q.rs1_addr),
    .rs_val        (stage_q.rs1_val),
    .exm_reg_write (bus.exm_reg_write),
    .exm_rd_addr   (bus.exm_rd_addr),
    .exm_result    (bus.exm_result),
    .mwb_reg_write (bus.mwb_reg_write),
    .mwb_rd_addr   (bus.mwb_rd_addr),
    .mwb_result    (bus.mwb_result),
    .fwd_val       (fwd_a)
  );

  fwd_mux u_fwd_b (
    .rs_addr       (stage_q.rs2_addr),
    .rs_val        (stage_q.rs2_val),
    .exm_reg_write (bus.exm_reg_write),
    .exm_rd_addr   (bus.exm_rd_addr),
    .exm_result    (bus.exm_result),
    .mwb_reg_write (bus.mwb_reg_write),
    .mwb_rd_addr   (bus.mwb_rd_addr),
    .mwb_result    (bus.mwb_result),
    .fwd_val       (fwd_b)
  );

  // An empty stage presents zero operands no matter what the buses carry.
  assign src_a = stage_q.valid ? fwd_a : '0;
  assign src_b = stage_q.valid ? fwd_b : '0;

  always_comb begin
    stage_next = stage_q;
    if (bus.flush) begin
      stage_next = bubble();
    end else if (bus.stall) begin
      stage_next.rs1_val = src_a;
      stage_next.rs2_val = src_b;
    end else if (bus.dec_valid) begin
      stage_next.valid     = 1'b1;
      stage_next.alu_op    = bus.dec_alu_op;
      stage_next.rs1_addr  = bus.dec_rs1_addr;
      stage_next.rs2_addr  = bus.dec_rs2_addr;
      stage_next.rs1_val   = bus.dec_rs1_val;
      stage_next.rs2_val   = bus.dec_rs2_val;
      stage_next.rd        = bus.dec_rd_addr;
      stage_next.reg_write = bus.dec_reg_write;
    end else begin
      stage_next = bubble();
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= bubble();
    end else begin
      stage_q <= stage_next;
    end
  end

  // Counts every stalled edge, flush or not; sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (bus.stall && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.ex_valid     = stage_q.valid;
  assign bus.ex_alu_op    = stage_q.alu_op;
  assign bus.ex_src_a     = src_a;
  assign bus.ex_src_b     = src_b;
  assign bus.ex_rd_addr   = stage_q.rd;
  assign bus.ex_reg_write = stage_q.reg_write;
  assign bus.stall_cnt    = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and randomized checks of id_ex_stage against a
// behavioural model of the stage held in plain variables.
module tb_id_ex_stage;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk;
  logic rst_n;

  id_ex_stage_if #(.CNT_W(CW)) bus ();

  id_ex_stage #(.CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors;
  int miscompares;

  // Model of the instruction currently held by the stage.
  logic       m_valid;
  logic [4:0] m_op;
  logic [3:0] m_rs1;
  logic [3:0] m_rs2;
  logic [7:0] m_v1;
  logic [7:0] m_v2;
  logic [3:0] m_rd;
  logic       m_rw;
  int         m_cnt;

  task automatic model_reset();
    m_valid = 0; m_op = 0; m_rs1 = 0; m_rs2 = 0;
    m_v1 = 0; m_v2 = 0; m_rd = 0; m_rw = 0; m_cnt = 0;
  endtask

  // Operand value the ALU should see for register a with stored value v.
  function automatic logic [7:0] exp_src(logic [3:0] a, logic [7:0] v);
    if (!m_valid) return 8'h00;
    if (a != 0 && bus.exm_reg_write && bus.exm_rd_addr == a) return bus.exm_result;
    if (a != 0 && bus.mwb_reg_write && bus.mwb_rd_addr == a) return bus.mwb_result;
    return v;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".valid"}, 32'(bus.ex_valid), 32'(m_valid));
    chk({tag, ".op"},    32'(bus.ex_alu_op), 32'(m_op));
    chk({tag, ".src_a"}, 32'(bus.ex_src_a), 32'(exp_src(m_rs1, m_v1)));
    chk({tag, ".src_b"}, 32'(bus.ex_src_b), 32'(exp_src(m_rs2, m_v2)));
    chk({tag, ".rd"},    32'(bus.ex_rd_addr), 32'(m_rd));
    chk({tag, ".rw"},    32'(bus.ex_reg_write), 32'(m_rw));
    chk({tag, ".cnt"},   32'(bus.stall_cnt), 32'(m_cnt));
  endtask

  // Advance one clock; the model takes the inputs present at the edge.
  task automatic step();
    logic [7:0] n1, n2;
    n1 = exp_src(m_rs1, m_v1);
    n2 = exp_src(m_rs2, m_v2);
    if (bus.stall && m_cnt < CMAX) m_cnt = m_cnt + 1;
    if (bus.flush) begin
      m_valid = 0; m_op = 0; m_rs1 = 0; m_rs2 = 0;
      m_v1 = 0; m_v2 = 0; m_rd = 0; m_rw = 0;
    end else if (bus.stall) begin
      m_v1 = n1;
      m_v2 = n2;
    end else if (bus.dec_valid) begin
      m_valid = 1; m_op = bus.dec_alu_op;
      m_rs1 = bus.dec_rs1_addr; m_rs2 = bus.dec_rs2_addr;
      m_v1 = bus.dec_rs1_val; m_v2 = bus.dec_rs2_val;
      m_rd = bus.dec_rd_addr; m_rw = bus.dec_reg_write;
    end else begin
      m_valid = 0; m_op = 0; m_rs1 = 0; m_rs2 = 0;
      m_v1 = 0; m_v2 = 0; m_rd = 0; m_rw = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(logic v, logic [4:0] op, logic [3:0] r1, logic [3:0] r2,
                         logic [7:0] v1, logic [7:0] v2, logic [3:0] rd, logic rw);
    bus.dec_valid = v; bus.dec_alu_op = op;
    bus.dec_rs1_addr = r1; bus.dec_rs2_addr = r2;
    bus.dec_rs1_val = v1; bus.dec_rs2_val = v2;
    bus.dec_rd_addr = rd; bus.dec_reg_write = rw;
  endtask

  task automatic set_fwd(logic ew, logic [3:0] ed, logic [7:0] er,
                         logic mw, logic [3:0] md, logic [7:0] mr);
    bus.exm_reg_write = ew; bus.exm_rd_addr = ed; bus.exm_result = er;
    bus.mwb_reg_write = mw; bus.mwb_rd_addr = md; bus.mwb_result = mr;
  endtask

  task automatic rand_dec();
    set_dec(1'($urandom_range(0, 3) != 0), 5'($urandom), 4'($urandom_range(0, 3)),
            4'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
            4'($urandom), 1'($urandom));
  endtask

  task automatic rand_fwd();
    set_fwd(1'($urandom), 4'($urandom_range(0, 3)), 8'($urandom),
            1'($urandom), 4'($urandom_range(0, 3)), 8'($urandom));
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    model_reset();
    rst_n = 1'b0;
    bus.stall = 0;
    bus.flush = 0;
    set_dec(0, 0, 0, 0, 0, 0, 0, 0);
    set_fwd(0, 0, 0, 0, 0, 0);
    #1;
    check_all("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all("reset_held");

    // Plain capture without forwarding.
    set_dec(1, 5'b00100, 4'd1, 4'd2, 8'h41, 8'h07, 4'd3, 1);
    step();
    check_all("capture");
    chk("capture.src_a_const", 32'(bus.ex_src_a), 32'h41);
    chk("capture.op_const", 32'(bus.ex_alu_op), 32'h04);

    // Forwarding priority on operand A.
    set_dec(1, 5'b00001, 4'd5, 4'd6, 8'h10, 8'h20, 4'd7, 1);
    step();
    set_fwd(1, 4'd5, 8'hAA, 1, 4'd5, 8'h55);
    #1;
    check_all("fwd_both");
    chk("fwd_both.const", 32'(bus.ex_src_a), 32'hAA);
    bus.exm_reg_write = 0;
    #1;
    check_all("fwd_mwb");
    chk("fwd_mwb.const", 32'(bus.ex_src_a), 32'h55);
    set_dec(1, 5'b00001, 4'd0, 4'd0, 8'h12, 8'h34, 4'd1, 1);
    set_fwd(1, 4'd0, 8'hAA, 1, 4'd0, 8'h55);
    step();
    check_all("fwd_r0");
    chk("fwd_r0.const", 32'(bus.ex_src_a), 32'h12);

    // Stall refresh: MEM/WB producer leaves during the stall.
    set_fwd(0, 0, 0, 0, 0, 0);
    set_dec(1, 5'b00001, 4'd1, 4'd2, 8'h01, 8'h11, 4'd4, 1);
    step();
    set_fwd(0, 0, 0, 1, 4'd2, 8'h3C);
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      rand_dec();
      step();
      check_all("stall");
    end
    bus.mwb_reg_write = 0;
    #1;
    check_all("stall_refresh");
    chk("stall_refresh.const", 32'(bus.ex_src_b), 32'h3C);
    chk("stall_cnt.const", 32'(bus.stall_cnt), 32'd3);

    // Flush wins over simultaneous stall.
    bus.stall = 0;
    set_dec(1, 5'b00100, 4'd3, 4'd3, 8'h55, 8'h66, 4'd9, 1);
    step();
    check_all("preflush");
    bus.stall = 1;
    bus.flush = 1;
    step();
    check_all("flush_stall");
    bus.flush = 0;
    bus.stall = 0;

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      rand_dec();
      rand_fwd();
      bus.stall = 1'($urandom_range(0, 3) == 0);
      bus.flush = 1'($urandom_range(0, 9) == 0);
      step();
      check_all("rand");
      rand_fwd();
      #1;
      check_all("rand_fwd");
    end

    // Saturation of the stall counter.
    bus.flush = 0;
    bus.stall = 1;
    for (int i = 0; i < 20; i++) begin
      rand_fwd();
      step();
      check_all("sat");
    end
    chk("sat.const", 32'(bus.stall_cnt), 32'hF);

    // Asynchronous reset in the middle of a stall with a valid instruction.
    bus.stall = 0;
    set_fwd(0, 0, 0, 0, 0, 0);
    set_dec(1, 5'b00100, 4'd1, 4'd2, 8'h77, 8'h88, 4'd5, 1);
    step();
    bus.stall = 1;
    step();
    check_all("pre_rst");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    chk("async_rst.valid_const", 32'(bus.ex_valid), 32'd0);
    #1;
    rst_n = 1'b1;
    bus.stall = 1;
    bus.flush = 0;
    set_dec(1, 5'b00100, 4'd1, 4'd2, 8'h21, 8'h43, 4'd6, 1);
    step();
    check_all("post_rst_stall");
    bus.stall = 0;
    step();
    check_all("post_rst_load");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
